// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, display FSM states and the RGB332 expander
// used by the framebuffer display stage.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int CNT_W    = 10;

   typedef enum logic [1:0] {WAIT_END, ARMED, SHOW} disp_state_t;

   // Bit replication keeps full-scale fields at FF and zero fields at 00.
   function automatic logic [23:0] rgb332_to_rgb888(input logic [7:0] pix);
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      r = pix[7:5];
      g = pix[4:2];
      b = pix[1:0];
      return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
   endfunction

endpackage

// File: rtl/vga_fb_display_if.sv
// Framebuffer read port, CPU END flag and VGA DAC pins of the display stage.
interface vga_fb_display_if #(
   parameter int ADDR_W = 16
);
   logic              END;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_rdata;
   logic              VGA_CLK;
   logic              VGA_HS;
   logic              VGA_VS;
   logic              VGA_SYNC_N;
   logic              VGA_BLANK_N;
   logic [7:0]        VGA_R;
   logic [7:0]        VGA_G;
   logic [7:0]        VGA_B;
   logic              frame_done;

   modport master (
      input  END, fb_rdata,
      output fb_addr, VGA_CLK, VGA_HS, VGA_VS, VGA_SYNC_N, VGA_BLANK_N,
             VGA_R, VGA_G, VGA_B, frame_done
   );

   modport slave (
      output END, fb_rdata,
      input  fb_addr, VGA_CLK, VGA_HS, VGA_VS, VGA_SYNC_N, VGA_BLANK_N,
             VGA_R, VGA_G, VGA_B, frame_done
   );
endinterface

// File: rtl/vga_timing.sv
// Pixel-rate enable, h/v raster counters and raw (unregistered) sync/active flags.
module vga_timing
   import vga_pkg::*;
(
   input  logic             clk_sys,
   input  logic             rst_n,
   output logic             pix_en,
   output logic [CNT_W-1:0] h,
   output logic [CNT_W-1:0] v,
   output logic             hs_raw,
   output logic             vs_raw,
   output logic             active,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_STOP  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_STOP  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic             pix_q;
   logic [CNT_W-1:0] h_q;
   logic [CNT_W-1:0] v_q;
   logic             h_last;
   logic             v_last;

   assign h_last = (h_q == H_LAST);
   assign v_last = (v_q == V_LAST);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= 1'b0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         pix_q <= ~pix_q;
         if (pix_q) begin
            if (h_last) begin
               h_q <= '0;
               v_q <= v_last ? '0 : v_q + ONE;
            end else begin
               h_q <= h_q + ONE;
            end
         end
      end
   end

   assign pix_en = pix_q;
   assign h      = h_q;
   assign v      = v_q;
   assign hs_raw = ~((h_q >= HS_START) && (h_q < HS_STOP));
   assign vs_raw = ~((v_q >= VS_START) && (v_q < VS_STOP));
   assign active = (h_q < H_ACT) && (v_q < V_ACT);
   assign wrap   = pix_q & h_last & v_last;

endmodule

// File: rtl/vga_fb_display.sv
// Display stage: raster timing, framebuffer fetch, one-pixel output register and
// the END-gated enable that blanks the image until the CPU has finished.
//
//   state    | meaning
//   WAIT_END | CPU still running, active area forced black
//   ARMED    | END seen, waiting for the next frame start
//   SHOW     | image displayed, held until reset
module vga_fb_display
   import vga_pkg::*;
#(
   parameter int          IMG_W  = 256,
   parameter int          IMG_H  = 256,
   parameter int          ADDR_W = 16,
   parameter logic [23:0] BG_RGB = 24'h0
) (
   input logic              CLOCK2_50,
   input logic              KEY,
   vga_fb_display_if.master vga
);

   localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);

   logic             pix_en;
   logic             hs_raw;
   logic             vs_raw;
   logic             active;
   logic             wrap;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   disp_state_t      state;
   disp_state_t      state_nx;
   logic [23:0]      rgb_c;
   logic [23:0]      rgb_q;
   logic             hs_q;
   logic             vs_q;
   logic             blank_q;
   logic             vclk_q;

   vga_timing u_timing (
      .clk_sys (CLOCK2_50),
      .rst_n   (KEY),
      .pix_en  (pix_en),
      .h       (h),
      .v       (v),
      .hs_raw  (hs_raw),
      .vs_raw  (vs_raw),
      .active  (active),
      .wrap    (wrap)
   );

   // RAM answers on the non-tick clock, so fb_rdata matches (h,v) at the next tick.
   assign vga.fb_addr = ADDR_W'(v[7:0]) * ADDR_W'(IMG_W) + ADDR_W'(h[7:0]);

   always_ff @(posedge CLOCK2_50 or negedge KEY) begin
      if (!KEY) begin
         state <= WAIT_END;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         WAIT_END: if (vga.END) state_nx = ARMED;
         ARMED:    if (wrap)    state_nx = SHOW;
         SHOW:                  state_nx = SHOW;
         default:               state_nx = WAIT_END;
      endcase
   end

   always_comb begin
      rgb_c = '0;
      if (active && (state == SHOW)) begin
         if ((h < IMG_W_C) && (v < IMG_H_C)) begin
            rgb_c = rgb332_to_rgb888(vga.fb_rdata);
         end else begin
            rgb_c = BG_RGB;
         end
      end
   end

   // Syncs share the colour's register stage so all pins lag the counters equally.
   always_ff @(posedge CLOCK2_50 or negedge KEY) begin
      if (!KEY) begin
         vclk_q  <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         rgb_q   <= '0;
      end else begin
         vclk_q <= pix_en;
         if (pix_en) begin
            hs_q    <= hs_raw;
            vs_q    <= vs_raw;
            blank_q <= active;
            rgb_q   <= rgb_c;
         end
      end
   end

   assign vga.VGA_CLK     = vclk_q;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.VGA_BLANK_N = blank_q;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.VGA_R       = rgb_q[23:16];
   assign vga.VGA_G       = rgb_q[15:8];
   assign vga.VGA_B       = rgb_q[7:0];
   assign vga.frame_done  = wrap;

endmodule

// File: tb/tb_vga_fb_display.sv
// Randomized bench for vga_fb_display against a pixel-index reference model;
// raster jumps fast-forward through the frame so wraps are reached quickly.
module tb_vga_fb_display;
   import vga_pkg::*;

   localparam int          FRAME = 800 * 525;
   localparam logic [23:0] BG    = 24'h3C5A96;

   logic clk_sys = 1'b0;
   logic rst_b   = 1'b1;

   always #10 clk_sys = ~clk_sys;

   vga_fb_display_if #(.ADDR_W(16)) vga ();

   vga_fb_display #(
      .IMG_W  (256),
      .IMG_H  (256),
      .ADDR_W (16),
      .BG_RGB (BG)
   ) dut (
      .CLOCK2_50 (clk_sys),
      .KEY       (rst_b),
      .vga       (vga)
   );

   logic [7:0]  mem [65536];
   logic [15:0] addr_prev;
   logic [9:0]  jump_h;
   logic [9:0]  jump_v;
   int          n_vec;
   int          n_bad;

   // reference model: pixel index since frame start, phase, capture of the output stage
   int          m_pix;
   bit          m_ph;
   bit          m_armed;
   bit          m_show;
   int          m_cap;
   logic [23:0] m_cap_rgb;
   bit          m_vclk;
   int          cyc;
   bit          cur_end;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (pix %0d, t=%0t)", tag, got, exp, m_pix, $time);
      end
   endtask

   function automatic logic [23:0] expand332(input logic [7:0] p);
      int r, g, b;
      r = (int'(p[7:5]) * 510 + 7) / 14;
      g = (int'(p[4:2]) * 510 + 7) / 14;
      b = int'(p[1:0]) * 85;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   function automatic int addr_of(input int p);
      return ((p / 800) % 256) * 256 + ((p % 800) % 256);
   endfunction

   function automatic logic [23:0] colour(input int p, input bit show);
      int hh, vv;
      hh = p % 800;
      vv = p / 800;
      if (!(hh < 640 && vv < 480) || !show) return 24'h0;
      if (hh < 256 && vv < 256) return expand332(mem[addr_of(p)]);
      return BG;
   endfunction

   task automatic model_reset();
      m_pix = 0; m_ph = 0; m_armed = 0; m_show = 0;
      m_cap = FRAME - 1; m_cap_rgb = '0; m_vclk = 0;
      addr_prev = '0; cyc = 0;
   endtask

   task automatic model_edge(input bit e);
      if (m_ph) begin
         m_cap     = m_pix;
         m_cap_rgb = colour(m_pix, m_show);
         if (m_pix == FRAME - 1 && m_armed) m_show = 1;
         m_pix = (m_pix + 1) % FRAME;
      end
      if (e) m_armed = 1;
      m_vclk = m_ph;
      m_ph   = !m_ph;
      cyc++;
   endtask

   task automatic check_all();
      int hq, vq;
      hq = m_cap % 800;
      vq = m_cap / 800;
      check("hs",     vga.VGA_HS,      32'(!(hq >= 656 && hq < 752)));
      check("vs",     vga.VGA_VS,      32'(!(vq >= 490 && vq < 492)));
      check("blank",  vga.VGA_BLANK_N, 32'(hq < 640 && vq < 480));
      check("rgb",    {vga.VGA_R, vga.VGA_G, vga.VGA_B}, m_cap_rgb);
      check("vclk",   vga.VGA_CLK,     32'(m_vclk));
      check("sync_n", vga.VGA_SYNC_N,  32'd0);
      check("fdone",  vga.frame_done,  32'(m_ph && m_pix == FRAME - 1));
      check("addr",   vga.fb_addr,     addr_of(m_pix));
   endtask

   task automatic step(input bit e);
      cur_end      = e;
      vga.END      = e;
      vga.fb_rdata = mem[addr_prev];
      addr_prev    = vga.fb_addr;
      model_edge(e);
      @(negedge clk_sys);
      check_all();
   endtask

   task automatic do_reset(input int n);
      rst_b = 1'b0;
      vga.END = 1'b0;
      cur_end = 0;
      vga.fb_rdata = 8'hFF;
      #1;
      model_reset();
      check_all();
      repeat (n) @(negedge clk_sys);
      check_all();
      rst_b = 1'b1;
   endtask

   task automatic jump(input int p);
      if (m_ph) step(cur_end);
      jump_h = 10'(p % 800);
      jump_v = 10'(p / 800);
      force dut.u_timing.h_q = jump_h;
      force dut.u_timing.v_q = jump_v;
      #1;
      release dut.u_timing.h_q;
      release dut.u_timing.v_q;
      #1;
      m_pix = p;
   endtask

   task automatic line_check(input string tag);
      int hs_low, first_fall;
      hs_low = 0;
      first_fall = -1;
      for (int i = 0; i < 1700; i++) begin
         step(0);
         if (vga.VGA_HS === 1'b0) begin
            if (cyc <= 1600) hs_low++;
            if (first_fall < 0) first_fall = cyc;
         end
      end
      check({tag, "_hs_low_clks"}, hs_low, 192);
      check({tag, "_hs_fall_clk"}, first_fall, 1314);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit done00, seen;
      int k, guard;
      n_vec = 0;
      n_bad = 0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hE0;
      model_reset();

      // reset, then a full line with END low
      do_reset(5);
      check("rst_addr", vga.fb_addr, 32'd0);
      line_check("run0");

      // END rises mid-frame; current frame black, image from next frame start
      jump(FRAME - 1500);
      k = $urandom_range(200, 2500);
      done00 = 0;
      for (int i = 0; i < 6400; i++) begin
         if (i > 3200) step(1'($urandom_range(0, 1)));
         else step(i >= k);
         if (m_show && m_cap == 0 && !done00) begin
            done00 = 1;
            check("px00_rgb", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 24'hFF0000);
         end
         if (m_show && m_pix == 1 && m_ph) check("px10_addr", vga.fb_addr, 32'd1);
      end
      check("px00_seen", 32'(done00), 32'd1);

      // background and blanking on line 10
      jump(10 * 800 + 290);
      for (int i = 0; i < 1000; i++) begin
         step(1'($urandom_range(0, 1)));
         if (m_cap == 10 * 800 + 300 && m_ph) begin
            check("bg_blank", vga.VGA_BLANK_N, 32'd1);
            check("bg_rgb", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, BG);
         end
         if (m_cap == 10 * 800 + 700 && m_ph) begin
            check("hb_blank", vga.VGA_BLANK_N, 32'd0);
            check("hb_rgb", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 32'd0);
         end
      end

      // last image pixel address
      jump(255 * 800 + 200);
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)));
         if (m_pix == 255 * 800 + 255 && m_ph) check("addr_ffff", vga.fb_addr, 32'hFFFF);
      end

      // random raster positions
      for (int j = 0; j < 8; j++) begin
         jump(int'($urandom_range(0, FRAME - 1)));
         for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)));
      end

      // END first seen on the wrap tick: that frame stays black, next one shows
      do_reset(3);
      jump(FRAME - 4);
      guard = 0;
      while (!(m_ph && m_pix == FRAME - 1) && guard < 20) begin
         step(0);
         guard++;
      end
      check("wrap_reached", 32'(guard < 20), 32'd1);
      step(1);
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         step(1);
         if (m_cap == 0 && m_ph && !seen) begin
            seen = 1;
            check("armed_px00_rgb", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 32'd0);
         end
      end
      jump(FRAME - 100);
      for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)));

      // asynchronous reset mid-frame at (400,200)
      jump(200 * 800 + 396);
      guard = 0;
      while (m_pix != 200 * 800 + 400 && guard < 20) begin
         step(1);
         guard++;
      end
      check("mid_reached", 32'(guard < 20), 32'd1);
      #2;
      rst_b = 1'b0;
      #1;
      model_reset();
      check("mid_rst_hs", vga.VGA_HS, 32'd1);
      check("mid_rst_vs", vga.VGA_VS, 32'd1);
      check("mid_rst_blank", vga.VGA_BLANK_N, 32'd0);
      check("mid_rst_rgb", {vga.VGA_R, vga.VGA_G, vga.VGA_B}, 32'd0);
      check("mid_rst_addr", vga.fb_addr, 32'd0);
      do_reset(3);
      line_check("run1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
